// File: rtl/cam_arbiter.sv
// Two-requester round-robin arbiter serialising read/write commands onto a single CAM port.
// Latency: write 3 cycles sample-to-done; read 3+k cycles (k = WAIT cycles until response, capped at TIMEOUT).
// Backpressure: one transaction in flight; requests are sampled only in IDLE, the other requester waits.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req[1:0], rw_n[1:0]       per-requester request and operation (1 = read, 0 = write)
//   key, wdata                per-requester key / write value, requester i at [i*W +: W]
//   gnt[1:0], done[1:0]       one-hot grant (whole transaction), one-hot completion pulse
//   rdata, err                read result and timeout flag, valid while done is high
//   busy                      high whenever a transaction is in progress
//   cam_valid_i, cam_rw_n,
//   cam_key, cam_val_i        CAM command strobe and fields
//   cam_valid_o, cam_val_o    CAM read response (hit)
module cam_arbiter #(
    parameter int KEY_W   = 16,
    parameter int VAL_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           req,
    input  logic [1:0]           rw_n,
    input  logic [2*KEY_W-1:0]   key,
    input  logic [2*VAL_W-1:0]   wdata,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic [VAL_W-1:0]     rdata,
    output logic                 err,
    output logic                 busy,
    output logic                 cam_rw_n,
    output logic                 cam_valid_i,
    output logic [KEY_W-1:0]     cam_key,
    output logic [VAL_W-1:0]     cam_val_i,
    input  logic                 cam_valid_o,
    input  logic [VAL_W-1:0]     cam_val_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter value seen during the last permitted WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_q, last_d;     // index of the requester granted most recently
    logic               rw_q, rw_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [VAL_W-1:0]   wdata_q, wdata_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [VAL_W-1:0]   rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               sel;
    logic               wait_hit;
    logic               wait_expire;

    // On a tie the requester that did not win last time goes first.
    assign sel         = (req == 2'b11) ? ~last_q : req[1];
    assign wait_hit    = cam_valid_o;
    assign wait_expire = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;            // makes requester 0 win the first tie
            rw_q    <= 1'b0;
            key_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            key_q   <= key_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = rw_q ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                // A response arriving on the final WAIT cycle still counts as a hit.
                if (wait_hit || wait_expire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d   = gnt_q;
        last_d  = last_q;
        rw_d    = rw_q;
        key_d   = key_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    last_d  = sel;
                    rw_d    = sel ? rw_n[1] : rw_n[0];
                    key_d   = sel ? key[2*KEY_W-1:KEY_W]   : key[KEY_W-1:0];
                    wdata_d = sel ? wdata[2*VAL_W-1:VAL_W] : wdata[VAL_W-1:0];
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (!rw_q) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (wait_hit) begin
                    rdata_d = cam_val_o;
                    err_d   = 1'b0;
                end else if (wait_expire) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // Result is only meaningful alongside done; clear it on the way out.
                gnt_d   = 2'b00;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: begin
                gnt_d = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        gnt         = gnt_q;
        done        = (state_q == S_DONE) ? gnt_q : 2'b00;
        busy        = (state_q != S_IDLE);
        cam_valid_i = (state_q == S_ISSUE);
        cam_rw_n    = rw_q;
        cam_key     = key_q;
        cam_val_i   = wdata_q;
        rdata       = rdata_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_cam_arbiter.sv
// Randomised scoreboard bench for cam_arbiter with a behavioural CAM and arbitration model.
// Latency: expected done cycle derived from grant cycle plus response delay.
// Backpressure: requesters hold req until done and drop it during the done cycle.
module tb_cam_arbiter;

    localparam int KEY_W   = 16;
    localparam int VAL_W   = 16;
    localparam int TIMEOUT = 8;

    logic                clk;
    logic                reset_n;
    logic [1:0]          req;
    logic [1:0]          rw_n;
    logic [2*KEY_W-1:0]  key;
    logic [2*VAL_W-1:0]  wdata;
    logic [1:0]          gnt;
    logic [1:0]          done;
    logic [VAL_W-1:0]    rdata;
    logic                err;
    logic                busy;
    logic                cam_rw_n;
    logic                cam_valid_i;
    logic [KEY_W-1:0]    cam_key;
    logic [VAL_W-1:0]    cam_val_i;
    logic                cam_valid_o;
    logic [VAL_W-1:0]    cam_val_o;

    cam_arbiter #(.KEY_W(KEY_W), .VAL_W(VAL_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .rw_n        (rw_n),
        .key         (key),
        .wdata       (wdata),
        .gnt         (gnt),
        .done        (done),
        .rdata       (rdata),
        .err         (err),
        .busy        (busy),
        .cam_rw_n    (cam_rw_n),
        .cam_valid_i (cam_valid_i),
        .cam_key     (cam_key),
        .cam_val_i   (cam_val_i),
        .cam_valid_o (cam_valid_o),
        .cam_val_o   (cam_val_o)
    );

    typedef struct {
        int          who;
        bit          rd;
        logic [15:0] k;
        logic [15:0] w;
        logic [15:0] rdat;
        bit          er;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          dly_q[$];
    logic [15:0] mem     [logic [15:0]];   // model's view of CAM contents
    logic [15:0] cam_mem [logic [15:0]];   // behavioural CAM contents
    int          last_gnt;
    int          checks;
    int          errors;
    int          cyc;
    bit          mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: one transaction in grant order.
    task automatic push_txn(input int who, input bit rd, input logic [15:0] k,
                            input logic [15:0] w, input int d);
        exp_t e;
        e.who = who; e.rd = rd; e.k = k; e.w = w;
        if (!rd) begin
            mem[k] = w;
            e.rdat = 16'h0; e.er = 1'b0; e.lat = 1;
        end else if (mem.exists(k) && d >= 1 && d <= TIMEOUT) begin
            e.rdat = mem[k]; e.er = 1'b0; e.lat = d + 1;
            dly_q.push_back(d);
        end else begin
            e.rdat = 16'h0; e.er = 1'b1; e.lat = TIMEOUT + 1;
            dly_q.push_back(0);
        end
        exp_q.push_back(e);
    endtask

    task automatic do_req(input logic [1:0] r, input logic [1:0] rw,
                          input logic [15:0] k0, input logic [15:0] k1,
                          input logic [15:0] w0, input logic [15:0] w1,
                          input int d0, input int d1);
        int order[2];
        int n;
        if (r == 2'b11) begin
            order[0] = (last_gnt == 0) ? 1 : 0;
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = r[1] ? 1 : 0;
            order[1] = 0;
            n = 1;
        end
        for (int i = 0; i < n; i++) begin
            push_txn(order[i], rw[order[i]], (order[i] == 1) ? k1 : k0,
                     (order[i] == 1) ? w1 : w0, (order[i] == 1) ? d1 : d0);
        end
        last_gnt = order[n-1];
        @(negedge clk);
        req   = r;
        rw_n  = rw;
        key   = {k1, k0};
        wdata = {w1, w0};
        for (int c = 0; c < 200 && req != 2'b00; c++) begin
            @(negedge clk);
            if (done[0]) req[0] = 1'b0;
            if (done[1]) req[1] = 1'b0;
        end
        check("done_wait", 64'(req), 64'd0);
        req = 2'b00;
    endtask

    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stray) begin
                cam_valid_o = 1'b1;
                cam_val_o   = 16'($urandom);
            end
            @(negedge clk);
            cam_valid_o = 1'b0;
            check("idle_out", {gnt, done, busy, err, cam_valid_i, rdata}, 64'd0);
        end
    endtask

    // Behavioural CAM: learns writes, answers reads after the scheduled delay.
    initial begin
        int          d;
        logic [15:0] kk;
        cam_valid_o = 1'b0;
        cam_val_o   = '0;
        forever begin
            @(negedge clk);
            if (cam_valid_i && reset_n) begin
                if (!cam_rw_n) begin
                    cam_mem[cam_key] = cam_val_i;
                end else begin
                    d  = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                    kk = cam_key;
                    if (d > 0 && cam_mem.exists(kk)) begin
                        repeat (d) @(negedge clk);
                        cam_valid_o = 1'b1;
                        cam_val_o   = cam_mem[kk];
                        @(negedge clk);
                        cam_valid_o = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares grants, commands and completions against the scoreboard.
    initial begin
        exp_t       e;
        logic [1:0] prev_gnt;
        bit         chk_busy;
        int         gnt_cyc;
        prev_gnt = 2'b00;
        chk_busy = 1'b0;
        gnt_cyc  = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                chk_busy = 1'b0;
            end else begin
                if (chk_busy) begin
                    check("busy_after_done", 64'(busy), 64'd0);
                    chk_busy = 1'b0;
                end
                if (prev_gnt == 2'b00 && gnt != 2'b00) begin
                    gnt_cyc = cyc;
                    if (exp_q.size() == 0) check("unexpected_gnt", 64'(gnt), 64'd0);
                    else check("gnt", 64'(gnt), 64'(2'b01 << exp_q[0].who));
                end
                if (cam_valid_i) begin
                    if (exp_q.size() == 0) check("unexpected_cmd", 64'(cam_valid_i), 64'd0);
                    else check("cam_cmd", {cam_rw_n, cam_key, cam_val_i},
                               {exp_q[0].rd, exp_q[0].k, exp_q[0].w});
                end
                if (done != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done",    64'(done),  64'(2'b01 << e.who));
                        check("rdata",   64'(rdata), 64'(e.rdat));
                        check("err",     64'(err),   64'(e.er));
                        check("latency", 64'(cyc - gnt_cyc), 64'(e.lat));
                        chk_busy = 1'b1;
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [15:0] pool [4];
        logic [1:0]  r;
        pool[0] = 16'h0012; pool[1] = 16'h0034; pool[2] = 16'h0056; pool[3] = 16'h0078;
        checks = 0; errors = 0; mon_en = 1'b0; last_gnt = 1;
        req = 2'b00; rw_n = 2'b00; key = '0; wdata = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("reset_out", {gnt, done, busy, err, cam_valid_i, cam_rw_n, rdata, cam_key, cam_val_i}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Write, read hit two cycles after ISSUE, timeout, boundary hit on the last WAIT cycle.
        do_req(2'b01, 2'b00, 16'h0012, 16'h0000, 16'hBEEF, 16'h0000, 0, 0);
        do_req(2'b10, 2'b10, 16'h0000, 16'h0012, 16'h0000, 16'h0000, 0, 2);
        do_req(2'b01, 2'b01, 16'h0999, 16'h0000, 16'h0000, 16'h0000, 1, 0);
        do_req(2'b10, 2'b10, 16'h0000, 16'h0012, 16'h0000, 16'h0000, 0, TIMEOUT);
        do_req(2'b01, 2'b01, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 1, 0);
        idle(3, 1'b1);

        // Reset while a read sits in WAIT.
        mon_en = 1'b0;
        @(negedge clk);
        req = 2'b01; rw_n = 2'b01; key = {16'h0000, 16'h0777}; wdata = '0;
        repeat (4) @(negedge clk);
        check("busy_in_wait", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_out", {gnt, done, busy, err, cam_valid_i, cam_rw_n, rdata, cam_key, cam_val_i}, 64'd0);
        req = 2'b00;
        exp_q.delete();
        dly_q.delete();
        last_gnt = 1;
        @(negedge clk);
        check("no_done_in_reset", 64'(done), 64'd0);
        reset_n = 1'b1;
        idle(2, 1'b1);
        mon_en = 1'b1;

        // Continuous contention: grants must alternate starting with requester 0.
        for (int i = 0; i < 3; i++) begin
            do_req(2'b11, 2'($urandom), pool[$urandom_range(3, 0)], pool[$urandom_range(3, 0)],
                   16'($urandom), 16'($urandom), $urandom_range(TIMEOUT + 1, 1),
                   $urandom_range(TIMEOUT + 1, 1));
        end

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            r = 2'($urandom_range(3, 1));
            do_req(r, 2'($urandom), pool[$urandom_range(3, 0)], pool[$urandom_range(3, 0)],
                   16'($urandom), 16'($urandom), $urandom_range(TIMEOUT + 1, 1),
                   $urandom_range(TIMEOUT + 1, 1));
            idle($urandom_range(2, 0), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
